// File: rtl/gear_shift_ctrl.sv
// gear_shift_ctrl: request-driven P/R/N/D selector with brake and speed
// interlocks and a timed pass through neutral on every real gear change.
// Optional build macro GEAR_AUTO_PARK_EN adds an idle auto-park from N to P.
module gear_shift_ctrl #(
  parameter int unsigned SHIFT_TICKS = 4,
  parameter int unsigned PARK_TICKS  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_shift,
  input  logic       req_valid,
  input  logic [3:0] req_gear,
  output logic       req_ready,
  input  logic [7:0] speed,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  output logic [3:0] current_gear,
  output logic       shift_busy,
  output logic       shift_done,
  output logic       reject,
  output logic [1:0] reject_code
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam logic [1:0] RJ_INVALID = 2'b01;
  localparam logic [1:0] RJ_BRAKE   = 2'b10;
  localparam logic [1:0] RJ_SPEED   = 2'b11;

  // Parameter range guards, evaluated at elaboration only
  if (SHIFT_TICKS < 1 || SHIFT_TICKS > 15) begin : g_bad_shift_ticks
    $error("SHIFT_TICKS must be in 1..15");
  end
  if (PARK_TICKS < 1) begin : g_bad_park_ticks
    $error("PARK_TICKS must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       gear_q, gear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic [1:0]       code_q, code_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef GEAR_AUTO_PARK_EN
  localparam int unsigned PW = $clog2(PARK_TICKS + 1);
  logic [PW-1:0] park_q, park_d;
`endif

  logic brake_on;
  logic speed_zero;
  logic tgt_valid;
  logic tgt_needs_stop;

  assign brake_on   = is_brake_normal | is_brake_hard;
  assign speed_zero = (speed == 8'd0);
  assign tgt_valid  = (target_q == GEAR_P) || (target_q == GEAR_R) ||
                      (target_q == GEAR_N) || (target_q == GEAR_D);
  // P or R targets, and direct D<->R reversals, are only legal at standstill
  assign tgt_needs_stop = (target_q == GEAR_P) || (target_q == GEAR_R) ||
                          ((gear_q == GEAR_D) && (target_q == GEAR_R)) ||
                          ((gear_q == GEAR_R) && (target_q == GEAR_D));

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    gear_d   = gear_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    code_d   = code_q;
    cnt_d    = cnt_q;
`ifdef GEAR_AUTO_PARK_EN
    park_d   = park_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          target_d = req_gear;
          state_d  = ST_CHECK;
        end
`ifdef GEAR_AUTO_PARK_EN
        if ((req_valid && ready_q) || !speed_zero || (gear_q != GEAR_N)) begin
          park_d = '0;
        end else if (tick_shift) begin
          if (park_q == PW'(PARK_TICKS - 1)) begin
            gear_d = GEAR_P;
            done_d = 1'b1;
            park_d = '0;
          end else begin
            park_d = park_q + PW'(1);
          end
        end
`endif
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (!tgt_valid) begin
          reject_d = 1'b1;
          code_d   = RJ_INVALID;
        end else if ((gear_q == GEAR_P) && (target_q != GEAR_P) && !brake_on) begin
          reject_d = 1'b1;
          code_d   = RJ_BRAKE;
        end else if (tgt_needs_stop && !speed_zero) begin
          reject_d = 1'b1;
          code_d   = RJ_SPEED;
        end else if (target_q == gear_q) begin
          done_d = 1'b1;
        end else begin
          gear_d  = GEAR_N;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Rolling while heading for P or R aborts and leaves the box in N
        if (((target_q == GEAR_P) || (target_q == GEAR_R)) && !speed_zero) begin
          reject_d = 1'b1;
          code_d   = RJ_SPEED;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (tick_shift) begin
          if (cnt_q == CNT_W'(SHIFT_TICKS - 1)) begin
            gear_d  = target_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset parks the gearbox
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= GEAR_P;
      gear_q   <= GEAR_P;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      code_q   <= 2'b00;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      gear_q   <= gear_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      code_q   <= code_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef GEAR_AUTO_PARK_EN
  // Idle-in-neutral tick counter for auto-park
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      park_q <= '0;
    end else begin
      park_q <= park_d;
    end
  end
`endif

  assign req_ready    = ready_q;
  assign current_gear = gear_q;
  assign shift_busy   = busy_q;
  assign shift_done   = done_q;
  assign reject       = reject_q;
  assign reject_code  = code_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Bench for gear_shift_ctrl: directed scenarios then randomized requests,
// checked against a transaction-level model of the gear rules.
module tb_gear_shift_ctrl;

  localparam int unsigned SHIFT_TICKS = 4;
  localparam int unsigned PARK_TICKS  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_shift = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_gear = 4'd0;
  logic       req_ready;
  logic [7:0] speed = 8'd0;
  logic       is_brake_normal = 1'b0;
  logic       is_brake_hard = 1'b0;
  logic [3:0] current_gear;
  logic       shift_busy;
  logic       shift_done;
  logic       reject;
  logic [1:0] reject_code;

  gear_shift_ctrl #(.SHIFT_TICKS(SHIFT_TICKS), .PARK_TICKS(PARK_TICKS)) dut (
    .clk(clk), .rst(rst), .tick_shift(tick_shift), .req_valid(req_valid),
    .req_gear(req_gear), .req_ready(req_ready), .speed(speed),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .current_gear(current_gear), .shift_busy(shift_busy),
    .shift_done(shift_done), .reject(reject), .reject_code(reject_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_gear = 3;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_gear(input int g);
    return (g == 3) || (g == 6) || (g == 9) || (g == 12);
  endfunction

  // Outcome of a request from the gear rules: 0 accept, else reject code
  function automatic int rule_code(input int cur, input int tgt, input bit brk, input int spd);
    if (!legal_gear(tgt)) return 1;
    if (cur == 3 && tgt != 3 && !brk) return 2;
    if (spd != 0 && (tgt == 3 || tgt == 6 || (cur == 12 && tgt == 6) ||
                     (cur == 6 && tgt == 12))) return 3;
    return 0;
  endfunction

  task automatic idle_cycle();
    req_valid  = 1'b0;
    tick_shift = 1'b0;
    @(negedge clk);
    check_val("idle_ready", req_ready, 1);
    check_val("idle_done", shift_done, 0);
    check_val("idle_reject", reject, 0);
    check_val("idle_busy", shift_busy, 0);
  endtask

  task automatic set_brake(input bit brk);
    int pick;
    pick = $urandom_range(0, 2);
    is_brake_normal = brk && (pick != 1);
    is_brake_hard   = brk && (pick != 0);
  endtask

  // raise_mode: 0 never raise speed mid-shift, 1 random, 2 first quiet cycle
  task automatic do_request(input int tgt, input bit brk, input int spd, input int raise_mode);
    int code;
    int ticks;
    bit raised;
    bit fin;
    idle_cycle();
    req_valid  = 1'b1;
    req_gear   = 4'(tgt);
    speed      = 8'(spd);
    set_brake(brk);
    @(negedge clk);
    check_val("check_ready", req_ready, 0);
    req_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0;
    code = rule_code(m_gear, tgt, brk, spd);
    if (code != 0) begin
      check_val("rej_pulse", reject, 1);
      check_val("rej_code", reject_code, code);
      check_val("rej_nodone", shift_done, 0);
      check_val("rej_gear", current_gear, m_gear);
      return;
    end
    if (tgt == m_gear) begin
      check_val("same_done", shift_done, 1);
      check_val("same_noreject", reject, 0);
      check_val("same_gear", current_gear, m_gear);
      return;
    end
    check_val("enter_n_gear", current_gear, 9);
    check_val("enter_busy", shift_busy, 1);
    check_val("enter_nodone", shift_done, 0);
    ticks  = 0;
    raised = 1'b0;
    fin    = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      tick_shift = 1'($urandom_range(0, 1));
      req_valid  = 1'($urandom_range(0, 1));
      req_gear   = 4'($urandom_range(0, 15));
      if (!raised && !tick_shift &&
          (raise_mode == 2 || (raise_mode == 1 && $urandom_range(0, 5) == 0))) begin
        raised = 1'b1;
        speed  = 8'($urandom_range(1, 255));
      end
      if (tick_shift) ticks++;
      @(negedge clk);
      req_valid  = 1'b0;
      tick_shift = 1'b0;
      check_val("no_both_pulses", int'(shift_done && reject), 0);
      if (raised && (tgt == 3 || tgt == 6)) begin
        check_val("abort_reject", reject, 1);
        check_val("abort_code", reject_code, 3);
        check_val("abort_gear", current_gear, 9);
        check_val("abort_busy", shift_busy, 0);
        m_gear = 9;
        fin = 1'b1;
      end else if (ticks == int'(SHIFT_TICKS)) begin
        check_val("shift_done", shift_done, 1);
        check_val("shift_gear", current_gear, tgt);
        check_val("shift_busy_clr", shift_busy, 0);
        m_gear = tgt;
        fin = 1'b1;
      end else begin
        check_val("shift_hold_gear", current_gear, 9);
        check_val("shift_hold_busy", shift_busy, 1);
        check_val("shift_hold_nodone", shift_done, 0);
        check_val("shift_hold_ready", req_ready, 0);
      end
    end
    if (!fin) check_val("shift_timeout", 0, 1);
  endtask

  task automatic park_idle_test();
    int dones;
    dones = 0;
    idle_cycle();
    speed = 8'd0;
    for (int i = 0; i < int'(PARK_TICKS) * 2 + 6; i++) begin
      tick_shift = (i % 2 == 0) && (i < int'(PARK_TICKS) * 2);
      @(negedge clk);
      tick_shift = 1'b0;
      dones += int'(shift_done);
    end
`ifdef GEAR_AUTO_PARK_EN
    check_val("park_gear", current_gear, 3);
    check_val("park_done_count", dones, 1);
    m_gear = 3;
`else
    check_val("nopark_gear", current_gear, 9);
    check_val("nopark_done_count", dones, 0);
`endif
  endtask

  initial begin
    int tgt;
    int spd;
    #12;
    check_val("rst_gear", current_gear, 3);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_busy", shift_busy, 0);
    check_val("rst_done", shift_done, 0);
    check_val("rst_reject", reject, 0);
    check_val("rst_code", reject_code, 0);
    @(negedge clk);
    rst = 1'b0;
    m_gear = 3;

    // P->D without brake refused, then with brake through N
    do_request(12, 1'b0, 0, 0);
    do_request(12, 1'b1, 0, 0);
    // D->R while rolling refused
    do_request(6, 1'b0, 40, 0);
    // D->P aborted by speed rising mid-shift
    do_request(3, 1'b0, 0, 2);
    // invalid code
    do_request(5, 1'b1, 0, 0);
    // back to D, then reset during D->N
    do_request(12, 1'b0, 0, 0);
    idle_cycle();
    req_valid = 1'b1;
    req_gear  = 4'd9;
    speed     = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("pre_rst_gear", current_gear, 9);
    tick_shift = 1'b1;
    @(negedge clk);
    tick_shift = 1'b0;
    rst = 1'b1;
    #1;
    check_val("midrst_gear", current_gear, 3);
    check_val("midrst_ready", req_ready, 1);
    check_val("midrst_busy", shift_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    m_gear = 3;

    // neutral at standstill with no requests
    do_request(9, 1'b1, 0, 0);
    park_idle_test();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        tgt = $urandom_range(0, 15);
        while (legal_gear(tgt)) tgt = $urandom_range(0, 15);
      end else begin
        tgt = 3 * $urandom_range(1, 4);
      end
      spd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : 0;
      do_request(tgt, 1'($urandom_range(0, 1)), spd, 1);
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
